// File: rtl/dg0045_pkg.sv
// Shared definitions for the DG0045 program-ROM fetch front end.
package dg0045_pkg;

  localparam int PC_W      = 10;
  localparam int PC_HALF_W = 5;

  // Instruction presented when a fetch times out
  localparam logic [7:0] DG_NOP = 8'h00;

  typedef enum logic [2:0] {
    SCAN_LO = 3'd0,
    SCAN_HI = 3'd1,
    CHECK   = 3'd2,
    REQ     = 3'd3,
    DONE    = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/dg0045_pc_sampler.sv
// Samples the multiplexed PC_HL bus in two halves, builds the candidate
// address {hi, lo} and compares it with the previous scan's candidate.
// Phase sequencing comes from the fetch FSM in the top level; this block
// owns the settle counter, the registered half select and the scan history.
module dg0045_pc_sampler
  import dg0045_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_lo,   // FSM is in SCAN_LO
  input  logic                 sample_hi,   // FSM is in SCAN_HI
  input  logic                 mux_next,    // half select for the next cycle
  input  logic                 clear_hist,  // forget the previous scan
  input  logic [PC_HALF_W-1:0] pc_hl,
  output logic                 pc_mux,
  output logic                 half_last,   // last settle cycle of a half
  output logic                 scan_done,   // hi half captured this cycle
  output logic                 stable,      // cand matches a valid previous scan
  output logic [PC_W-1:0]      cand
);

  logic [2:0]           settle_cnt;
  logic [PC_HALF_W-1:0] lo;
  logic [PC_HALF_W-1:0] hi;
  logic [PC_W-1:0]      prev_cand;
  logic                 hist_valid;
  logic                 record;

  assign half_last = (sample_lo || sample_hi) && (settle_cnt == 3'(SETTLE_CYCLES));
  assign scan_done = sample_hi && half_last;
  assign cand      = {hi, lo};
  assign stable    = hist_valid && (cand == prev_cand);

  // Settle counter: runs through each half, restarts at every half boundary
  always_ff @(posedge clk) begin
    if (rst || !(sample_lo || sample_hi) || half_last) begin
      settle_cnt <= 3'd0;
    end else begin
      settle_cnt <= settle_cnt + 3'd1;
    end
  end

  // Half select is registered so it only changes on a phase boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mux <= 1'b0;
    end else begin
      pc_mux <= mux_next;
    end
  end

  // Capture each half on its last settle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if (sample_lo && half_last) lo <= pc_hl;
      if (sample_hi && half_last) hi <= pc_hl;
    end
  end

  // Scan history: record the candidate during the check cycle after a scan
  always_ff @(posedge clk) begin
    if (rst) begin
      record     <= 1'b0;
      hist_valid <= 1'b0;
      prev_cand  <= '0;
    end else begin
      record <= scan_done;
      if (clear_hist) begin
        hist_valid <= 1'b0;
      end else if (record) begin
        prev_cand  <= cand;
        hist_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dg0045_rom_fetch.sv
// Program-ROM fetch front end for the DG0045 core: scans the PC in two
// halves, waits for two agreeing scans, then fetches the byte over req/ack.
//
// Memory handshake: mem_req is held high with mem_addr constant until the
// cycle in which mem_ack is high; that cycle transfers mem_data and the
// request drops on the next edge. mem_ack outside a request is ignored.
// If no ack arrives within TIMEOUT request cycles the fetch ends with a NOP
// and the sticky err flag.
module dg0045_rom_fetch
  import dg0045_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_HALF_W-1:0] pc_hl_i,
  output logic                 pc_mux_o,
  output logic                 mem_req_o,
  output logic [PC_W-1:0]      mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [7:0]           mem_data_i,
  output logic [7:0]           instr_o,
  output logic                 instr_valid_o,
  output logic                 err_o
);

  fetch_state_t    state;
  fetch_state_t    next_state;

  logic            half_last;
  logic            scan_done;
  logic            stable;
  logic [PC_W-1:0] cand;

  logic [7:0]      tcnt;
  logic            timeout;
  logic            fetch_go;
  logic            take_ack;
  logic            take_nop;
  logic            sample_lo;
  logic            sample_hi;
  logic            clear_hist;
  logic            mux_next;

  dg0045_pc_sampler #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .sample_lo (sample_lo),
    .sample_hi (sample_hi),
    .mux_next  (mux_next),
    .clear_hist(clear_hist),
    .pc_hl     (pc_hl_i),
    .pc_mux    (pc_mux_o),
    .half_last (half_last),
    .scan_done (scan_done),
    .stable    (stable),
    .cand      (cand)
  );

  // tcnt holds the number of request cycles already completed, so the
  // timeout fires in the request cycle that makes the total TIMEOUT.
  assign timeout = (state == REQ) && (tcnt >= 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN_LO;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      SCAN_LO: if (half_last) next_state = SCAN_HI;
      SCAN_HI: if (scan_done) next_state = CHECK;
      CHECK:   next_state = fetch_go ? REQ : SCAN_LO;
      REQ:     if (take_ack || take_nop) next_state = DONE;
      DONE:    next_state = SCAN_LO;
      default: next_state = SCAN_LO;
    endcase
  end

  // Output decode: strobes for the sampler and the output registers
  always_comb begin
    sample_lo  = (state == SCAN_LO);
    sample_hi  = (state == SCAN_HI);
    clear_hist = (state == DONE);
    mux_next   = (next_state != SCAN_LO);
    // Fetch on a stable address that differs from the held one, or when
    // nothing has been fetched yet (instr_valid is only low then).
    fetch_go   = (state == CHECK) && stable &&
                 ((cand != mem_addr_o) || !instr_valid_o);
    take_ack   = (state == REQ) && mem_ack_i;
    take_nop   = (state == REQ) && !mem_ack_i && timeout;
  end

  // Timeout counter: cleared when a request starts, saturating at 8'hFF
  always_ff @(posedge clk) begin
    if (rst || fetch_go) begin
      tcnt <= 8'd0;
    end else if ((state == REQ) && (tcnt != 8'hFF)) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // Output registers: request, address, instruction, valid and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      instr_o       <= DG_NOP;
      instr_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      mem_req_o <= (next_state == REQ);
      if (fetch_go) begin
        mem_addr_o    <= cand;
        instr_valid_o <= 1'b0;
      end
      if (take_ack) begin
        instr_o       <= mem_data_i;
        instr_valid_o <= 1'b1;
      end
      if (take_nop) begin
        instr_o       <= DG_NOP;
        instr_valid_o <= 1'b1;
        err_o         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dg0045_rom_fetch.sv
// Self-checking bench for dg0045_rom_fetch: directed PC patterns, a simple
// core/memory model, and a scoreboard of expected fetch completions.
module tb_dg0045_rom_fetch;

  localparam int W = 27;  // {err, req_len[7:0], addr[9:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] core_lo = 5'h00;
  logic [4:0] core_hi = 5'h00;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'hEE;
  logic [7:0] instr;
  logic       instr_valid;
  logic       err;

  // Core model: PC_HL follows the half select combinationally
  assign pc_hl = pc_mux ? core_hi : core_lo;

  dg0045_rom_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_hl_i      (pc_hl),
    .pc_mux_o     (pc_mux),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .err_o        (err)
  );

  // ---------------- bookkeeping ----------------
  logic [W-1:0] exp_q[$];
  int           cmp_cnt  = 0;
  int           err_cnt  = 0;
  int           done_cnt = 0;
  int           req_cnt  = 0;
  int           n;
  int           base;

  // memory model controls
  logic         ack_en    = 1'b1;
  int           ack_delay = 0;
  logic [7:0]   mem_val   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic e, input logic [7:0] len,
                          input logic [9:0] addr, input logic [7:0] data);
    exp_q.push_back({e, len, addr, data});
  endtask

  task automatic wait_fetch(input int max, input string name);
    int start;
    int cyc;
    start = done_cnt;
    cyc   = 0;
    while (done_cnt == start && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    cmp_cnt++;
    if (done_cnt == start) begin
      err_cnt++;
      $display("FAIL %s: no fetch completed within %0d cycles", name, max);
    end
  endtask

  // ---------------- memory driver ----------------
  // Acks in request cycle ack_delay+1; data is garbage outside the ack cycle
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        rc      = 0;
        mem_ack = 1'b0;
      end else begin
        rc++;
        mem_ack = ack_en && (rc == ack_delay + 1);
      end
      mem_data = mem_ack ? mem_val : 8'hEE;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int           len;
    int           last_len;
    logic         prev_req;
    logic         prev_valid;
    logic [W-1:0] e;
    len        = 0;
    last_len   = 0;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        len++;
      end else begin
        if (prev_req) last_len = len;
        len = 0;
      end
      if (mem_req && !prev_req) req_cnt++;
      if (instr_valid && !prev_valid && !rst) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_fetch: addr %0h instr %0h with nothing expected", mem_addr, instr);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_addr",    mem_addr, {22'd0, e[17:8]});
          chk("fetch_instr",   instr,    {24'd0, e[7:0]});
          chk("fetch_err",     err,      {31'd0, e[26]});
          chk("fetch_req_len", last_len, {24'd0, e[25:18]});
        end
      end
      prev_req   = mem_req;
      prev_valid = instr_valid;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc_mux",      pc_mux,      0);
    chk("rst_mem_req",     mem_req,     0);
    chk("rst_mem_addr",    mem_addr,    0);
    chk("rst_instr",       instr,       0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_err",         err,         0);

    // Address 0, ack after 2 cycles with 3A: request after exactly two scans
    core_lo = 5'h00; core_hi = 5'h00;
    ack_en = 1'b1; ack_delay = 2; mem_val = 8'h3A;
    push_exp(1'b0, 8'd3, 10'h000, 8'h3A);
    rst = 1'b0;
    n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_latency", n, 10);
    chk("first_req_addr", mem_addr, 10'h000);
    wait_fetch(50, "fetch_000");

    // PC held at 2D5: one fetch, then nothing for 11 more scans
    core_lo = 5'h15; core_hi = 5'h16;
    ack_delay = 0; mem_val = 8'hC3;
    push_exp(1'b0, 8'd1, 10'h2D5, 8'hC3);
    base = req_cnt;
    wait_fetch(60, "fetch_2d5");
    repeat (55) @(negedge clk);
    chk("req_count_const_pc", req_cnt - base, 1);

    // Hi half moves every scan, then settles: only the final address fetched
    mem_val = 8'h5E;
    push_exp(1'b0, 8'd1, 10'h06A, 8'h5E);
    base = req_cnt;
    core_lo = 5'h0A; core_hi = 5'h01;
    repeat (5) @(negedge clk);
    core_hi = 5'h02;
    repeat (5) @(negedge clk);
    core_hi = 5'h03;
    wait_fetch(60, "fetch_06a");
    repeat (20) @(negedge clk);
    chk("req_count_hi_change", req_cnt - base, 1);

    // No ack: 15-cycle request, NOP, sticky error
    ack_en = 1'b0; mem_val = 8'h77;
    core_lo = 5'h15; core_hi = 5'h0A;
    push_exp(1'b1, 8'd15, 10'h155, 8'h00);
    wait_fetch(80, "fetch_timeout");
    repeat (20) @(negedge clk);
    chk("err_sticky", err, 1);

    // Reset clears the error
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_cleared_by_rst", err, 0);

    // Ack on the same cycle the timeout is reached: data wins, no error
    core_lo = 5'h1F; core_hi = 5'h1F;
    ack_en = 1'b1; ack_delay = 14; mem_val = 8'hA5;
    push_exp(1'b0, 8'd15, 10'h3FF, 8'hA5);
    rst = 1'b0;
    wait_fetch(80, "fetch_ack_at_timeout");

    // Reset in the middle of a request
    ack_en = 1'b0;
    core_lo = 5'h03; core_hi = 5'h06;
    n = 0;
    while (!mem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("midreq_addr", mem_addr, 10'h0C3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreq_rst_pc_mux",      pc_mux,      0);
    chk("midreq_rst_mem_req",     mem_req,     0);
    chk("midreq_rst_mem_addr",    mem_addr,    0);
    chk("midreq_rst_instr",       instr,       0);
    chk("midreq_rst_instr_valid", instr_valid, 0);
    chk("midreq_rst_err",         err,         0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
